// File: rtl/u_sadd_pkg.sv
// rtl/u_sadd_pkg.sv - shared defaults and width derivations for the unipolar scaled adder
package u_sadd_pkg;

    localparam int DEF_NUM_IN = 16;

    // Popcount must represent 0..numIn inclusive
    function automatic int cntWidth(input int numIn);
        return $clog2(numIn + 1);
    endfunction

    // Residue plus a full popcount peaks at 2*numIn-1
    function automatic int accWidth(input int numIn);
        return $clog2(2 * numIn);
    endfunction

endpackage

// File: rtl/u_sadd_popcnt.sv
// rtl/u_sadd_popcnt.sv - combinational ones count of the input stream vector
module u_sadd_popcnt
    import u_sadd_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int CNT_W  = cntWidth(NUM_IN)
) (
    input  logic [NUM_IN-1:0] in,
    output logic [CNT_W-1:0]  cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            cnt = cnt + CNT_W'(in[i]);
        end
    end

endmodule

// File: rtl/u_sadd_uni.sv
// rtl/u_sadd_uni.sv - unipolar stochastic scaled adder, emits one 1 per NUM_IN input ones
module u_sadd_uni
    import u_sadd_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int CNT_W  = cntWidth(NUM_IN),
    parameter int ACC_W  = accWidth(NUM_IN)
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic [NUM_IN-1:0] in,
    output logic              out
);

    localparam logic [ACC_W-1:0] THRESH = ACC_W'(NUM_IN);

    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             carry;

    u_sadd_popcnt #(
        .NUM_IN (NUM_IN),
        .CNT_W  (CNT_W)
    ) uPopcnt (
        .in  (in),
        .cnt (cnt)
    );

    // acc < NUM_IN and cnt <= NUM_IN, so sum fits ACC_W without wrap
    always_comb begin
        sum   = acc + ACC_W'(cnt);
        carry = (sum >= THRESH);
    end

    // iRstN is active-high despite its name
    always_ff @(posedge iClk) begin
        if (iRstN) begin
            acc <= '0;
            out <= 1'b0;
        end else begin
            out <= carry;
            acc <= carry ? (sum - THRESH) : sum;
        end
    end

endmodule

// File: tb/tb_u_sadd_uni.sv
// tb/tb_u_sadd_uni.sv - self-checking bench for u_sadd_uni
module tb_u_sadd_uni;

    localparam int N = 16;

    logic         iClk;
    logic         iRstN;
    logic [N-1:0] in;
    logic         out;

    int compared;
    int mismatched;

    // Reference: running totals since last reset; output is the step in floor(total/N)
    int totalIn;
    int totalOut;

    u_sadd_uni #(.NUM_IN(N)) dut (
        .iClk  (iClk),
        .iRstN (iRstN),
        .in    (in),
        .out   (out)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic stepDir(input string tag, input logic [N-1:0] v, input int expOut, input int expAcc);
        in = v;
        @(posedge iClk);
        #1;
        check({tag, "_out"}, {31'b0, out}, expOut);
        check({tag, "_acc"}, 32'(dut.acc), expAcc);
    endtask

    task automatic stepRst(input string tag, input logic [N-1:0] v);
        iRstN = 1'b1;
        in    = v;
        @(posedge iClk);
        #1;
        check({tag, "_out"}, {31'b0, out}, 0);
        check({tag, "_acc"}, 32'(dut.acc), 0);
        iRstN = 1'b0;
    endtask

    initial begin
        int ones, expOut;
        logic [N-1:0] v;
        compared   = 0;
        mismatched = 0;
        iRstN      = 1'b1;
        in         = '0;

        // Reset for two cycles with all inputs high
        iRstN = 1'b1;
        in    = 16'hFFFF;
        @(posedge iClk); #1;
        check("rst0_out", {31'b0, out}, 0);
        @(posedge iClk); #1;
        check("rst1_out", {31'b0, out}, 0);
        check("rst1_acc", 32'(dut.acc), 0);
        iRstN = 1'b0;
        for (int i = 0; i < 3; i++) stepDir("full", 16'hFFFF, 1, 0);

        // Half density from acc=0
        stepRst("rstA", 16'h0000);
        for (int i = 0; i < 2; i++) begin
            stepDir("half", 16'hFF00, 0, 8);
            stepDir("half", 16'hFF00, 1, 0);
        end

        // Quarter density from acc=0
        for (int i = 0; i < 2; i++) begin
            stepDir("quar", 16'hF000, 0, 4);
            stepDir("quar", 16'hF000, 0, 8);
            stepDir("quar", 16'hF000, 0, 12);
            stepDir("quar", 16'hF000, 1, 0);
        end

        // Pattern switch carries the residue
        stepDir("sw_pre", 16'hFF00, 0, 8);
        stepDir("sw0", 16'hF000, 0, 12);
        stepDir("sw1", 16'hF000, 1, 0);
        stepDir("sw2", 16'hF000, 0, 4);
        stepDir("sw3", 16'hF000, 0, 8);
        stepDir("sw4", 16'hF000, 0, 12);
        stepDir("sw5", 16'hF000, 1, 0);
        stepDir("sw6", 16'hF000, 0, 4);
        stepDir("zero0", 16'h0000, 0, 4);
        stepDir("zero1", 16'h0000, 0, 4);

        // Reset mid-stream discards acc=12
        stepDir("mid_pre0", 16'hF000, 0, 8);
        stepDir("mid_pre1", 16'hF000, 0, 12);
        stepRst("midRst", 16'hF000);
        stepDir("post1", 16'hF000, 0, 4);
        stepDir("post2", 16'hF000, 0, 8);
        stepDir("post3", 16'hF000, 0, 12);
        stepDir("post4", 16'hF000, 1, 0);

        // Random streams against the running-total reference
        stepRst("rstR", 16'h0000);
        totalIn  = 0;
        totalOut = 0;
        for (int i = 0; i < 1000; i++) begin
            v = N'($urandom);
            if (i % 7 == 3) v = '0;
            if (i % 11 == 5) v = '1;
            ones = $countones(v);
            expOut = ((totalIn + ones) / N) - (totalIn / N);
            totalIn += ones;
            in = v;
            @(posedge iClk);
            #1;
            totalOut += int'(out);
            check("rnd_out", {31'b0, out}, expOut);
            check("rnd_acc", 32'(dut.acc), totalIn % N);
        end
        check("rnd_total", totalOut, totalIn / N);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
